// File: rtl/lm32_x_result_stage_pkg.sv
// lm32_x_result_stage_pkg
//   Shared definitions for the execute-stage result path: datapath and
//   register index widths, and the encoding of the X-stage result select.
//   Imported by lm32_x_result_stage and lm32_bypass_mux.
package lm32_x_result_stage_pkg;

  localparam int LM32_WORD_WIDTH    = 32;
  localparam int LM32_REG_IDX_WIDTH = 5;

  // Which functional unit drives the X-stage result.
  typedef enum logic [1:0] {
    LM32_XRES_LOGIC = 2'd0,
    LM32_XRES_ADDER = 2'd1,
    LM32_XRES_SHIFT = 2'd2,
    LM32_XRES_CSR   = 2'd3
  } xres_sel_e;

endpackage

// File: rtl/lm32_bypass_mux.sv
// lm32_bypass_mux
//   Purely combinational operand forwarding for one D-stage source operand.
//   Chooses the youngest in-flight producer of the requested register:
//   X result, then M operand, then W operand, else the register file value.
//   Register 0 is hardwired zero, so it always takes the register file value.
// Ports:
//   read_idx_i       D-stage source register index
//   reg_data_i       register file read data for that index
//   x_fwd_en_i       X holds a live (valid, not killed) writing instruction
//   x_idx_i/x_data_i X destination index and combinational result
//   m_we_i/m_idx_i/m_data_i  qualified M write enable, index, operand
//   w_we_i/w_idx_i/w_data_i  qualified W write enable, index, operand
//   bypass_data_o    forwarded operand
module lm32_bypass_mux
  import lm32_x_result_stage_pkg::*;
#(
  parameter int WORD_WIDTH    = LM32_WORD_WIDTH,
  parameter int REG_IDX_WIDTH = LM32_REG_IDX_WIDTH
) (
  input  logic [REG_IDX_WIDTH-1:0] read_idx_i,
  input  logic [WORD_WIDTH-1:0]    reg_data_i,
  input  logic                     x_fwd_en_i,
  input  logic [REG_IDX_WIDTH-1:0] x_idx_i,
  input  logic [WORD_WIDTH-1:0]    x_data_i,
  input  logic                     m_we_i,
  input  logic [REG_IDX_WIDTH-1:0] m_idx_i,
  input  logic [WORD_WIDTH-1:0]    m_data_i,
  input  logic                     w_we_i,
  input  logic [REG_IDX_WIDTH-1:0] w_idx_i,
  input  logic [WORD_WIDTH-1:0]    w_data_i,
  output logic [WORD_WIDTH-1:0]    bypass_data_o
);

  logic hit_x;
  logic hit_m;
  logic hit_w;
  logic idx_nonzero;

  assign idx_nonzero = (read_idx_i != '0);
  assign hit_x       = x_fwd_en_i & (x_idx_i == read_idx_i);
  assign hit_m       = m_we_i & (m_idx_i == read_idx_i);
  assign hit_w       = w_we_i & (w_idx_i == read_idx_i);

  always_comb begin
    bypass_data_o = reg_data_i;
    if (idx_nonzero) begin
      // Youngest producer wins.
      if (hit_x) begin
        bypass_data_o = x_data_i;
      end else if (hit_m) begin
        bypass_data_o = m_data_i;
      end else if (hit_w) begin
        bypass_data_o = w_data_i;
      end
    end
  end

endmodule

// File: rtl/lm32_x_result_stage.sv
// lm32_x_result_stage
//   Selects the X-stage result from the functional units, carries it with its
//   destination index through the X->M and M->W pipeline registers (stall,
//   kill and bubble handling), and forwards in-flight results to both D-stage
//   source operands.
// Ports:
//   clk_i, rst_i            clock, synchronous active-low reset
//   *_result_x, csr_read_data_x, result_sel_x   functional unit results/select
//   write_idx_x, write_enable_x, valid_x        X destination info
//   stall_x, kill_x, stall_m, kill_m            pipeline control
//   read_idx_k_d, reg_data_k_d                  D-stage sources and RF data
//   x_result                selected X result (combinational)
//   operand_m, write_idx_m, write_enable_m, valid_m   M stage state
//   operand_w, write_idx_w, write_enable_w            W stage writeback
//   bypass_data_k_d         forwarded D operands (combinational)
module lm32_x_result_stage
  import lm32_x_result_stage_pkg::*;
#(
  parameter int WORD_WIDTH    = LM32_WORD_WIDTH,
  parameter int REG_IDX_WIDTH = LM32_REG_IDX_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [WORD_WIDTH-1:0]    logic_result_x,
  input  logic [WORD_WIDTH-1:0]    adder_result_x,
  input  logic [WORD_WIDTH-1:0]    shifter_result_x,
  input  logic [WORD_WIDTH-1:0]    csr_read_data_x,
  input  logic [1:0]               result_sel_x,
  input  logic [REG_IDX_WIDTH-1:0] write_idx_x,
  input  logic                     write_enable_x,
  input  logic                     valid_x,
  input  logic                     stall_x,
  input  logic                     kill_x,
  input  logic                     stall_m,
  input  logic                     kill_m,
  input  logic [REG_IDX_WIDTH-1:0] read_idx_0_d,
  input  logic [REG_IDX_WIDTH-1:0] read_idx_1_d,
  input  logic [WORD_WIDTH-1:0]    reg_data_0_d,
  input  logic [WORD_WIDTH-1:0]    reg_data_1_d,
  output logic [WORD_WIDTH-1:0]    x_result,
  output logic [WORD_WIDTH-1:0]    operand_m,
  output logic [REG_IDX_WIDTH-1:0] write_idx_m,
  output logic                     write_enable_m,
  output logic                     valid_m,
  output logic [WORD_WIDTH-1:0]    operand_w,
  output logic [REG_IDX_WIDTH-1:0] write_idx_w,
  output logic                     write_enable_w,
  output logic [WORD_WIDTH-1:0]    bypass_data_0_d,
  output logic [WORD_WIDTH-1:0]    bypass_data_1_d
);

  // M stage state
  logic [WORD_WIDTH-1:0]    operand_m_q, operand_m_d;
  logic [REG_IDX_WIDTH-1:0] write_idx_m_q, write_idx_m_d;
  logic                     we_m_q, we_m_d;
  logic                     valid_m_q, valid_m_d;
  // W stage state
  logic [WORD_WIDTH-1:0]    operand_w_q, operand_w_d;
  logic [REG_IDX_WIDTH-1:0] write_idx_w_q, write_idx_w_d;
  logic                     we_w_q, we_w_d;
  logic                     valid_w_q, valid_w_d;

  logic x_fwd_en;

  // Result select: zero-latency mux.
  always_comb begin
    x_result = logic_result_x;
    case (xres_sel_e'(result_sel_x))
      LM32_XRES_LOGIC: x_result = logic_result_x;
      LM32_XRES_ADDER: x_result = adder_result_x;
      LM32_XRES_SHIFT: x_result = shifter_result_x;
      LM32_XRES_CSR:   x_result = csr_read_data_x;
      default:         x_result = logic_result_x;
    endcase
  end

  // Next-state for the X->M and M->W registers.
  always_comb begin
    operand_m_d   = operand_m_q;
    write_idx_m_d = write_idx_m_q;
    we_m_d        = we_m_q;
    valid_m_d     = valid_m_q;
    if (!stall_m) begin
      operand_m_d   = x_result;
      write_idx_m_d = write_idx_x;
      we_m_d        = write_enable_x;
      // A stalled or killed X leaves a bubble behind it.
      valid_m_d     = valid_x & ~stall_x & ~kill_x;
    end
    // A squashed M instruction is invalidated even while M is stalled;
    // its data is simply left in place.
    if (kill_m) begin
      valid_m_d = 1'b0;
    end

    // W never stalls: it always takes whatever M holds, and only marks it
    // valid when M actually advances.
    operand_w_d   = operand_m_q;
    write_idx_w_d = write_idx_m_q;
    we_w_d        = we_m_q;
    valid_w_d     = valid_m_q & ~stall_m & ~kill_m;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      operand_m_q   <= '0;
      write_idx_m_q <= '0;
      we_m_q        <= 1'b0;
      valid_m_q     <= 1'b0;
      operand_w_q   <= '0;
      write_idx_w_q <= '0;
      we_w_q        <= 1'b0;
      valid_w_q     <= 1'b0;
    end else begin
      operand_m_q   <= operand_m_d;
      write_idx_m_q <= write_idx_m_d;
      we_m_q        <= we_m_d;
      valid_m_q     <= valid_m_d;
      operand_w_q   <= operand_w_d;
      write_idx_w_q <= write_idx_w_d;
      we_w_q        <= we_w_d;
      valid_w_q     <= valid_w_d;
    end
  end

  assign operand_m      = operand_m_q;
  assign write_idx_m    = write_idx_m_q;
  assign valid_m        = valid_m_q;
  assign write_enable_m = we_m_q & valid_m_q;
  assign operand_w      = operand_w_q;
  assign write_idx_w    = write_idx_w_q;
  assign write_enable_w = we_w_q & valid_w_q;

  // A killed X instruction never produces a value, so it must not forward.
  assign x_fwd_en = valid_x & write_enable_x & ~kill_x;

  lm32_bypass_mux #(
    .WORD_WIDTH    (WORD_WIDTH),
    .REG_IDX_WIDTH (REG_IDX_WIDTH)
  ) u_bypass_0 (
    .read_idx_i    (read_idx_0_d),
    .reg_data_i    (reg_data_0_d),
    .x_fwd_en_i    (x_fwd_en),
    .x_idx_i       (write_idx_x),
    .x_data_i      (x_result),
    .m_we_i        (write_enable_m),
    .m_idx_i       (write_idx_m_q),
    .m_data_i      (operand_m_q),
    .w_we_i        (write_enable_w),
    .w_idx_i       (write_idx_w_q),
    .w_data_i      (operand_w_q),
    .bypass_data_o (bypass_data_0_d)
  );

  lm32_bypass_mux #(
    .WORD_WIDTH    (WORD_WIDTH),
    .REG_IDX_WIDTH (REG_IDX_WIDTH)
  ) u_bypass_1 (
    .read_idx_i    (read_idx_1_d),
    .reg_data_i    (reg_data_1_d),
    .x_fwd_en_i    (x_fwd_en),
    .x_idx_i       (write_idx_x),
    .x_data_i      (x_result),
    .m_we_i        (write_enable_m),
    .m_idx_i       (write_idx_m_q),
    .m_data_i      (operand_m_q),
    .w_we_i        (write_enable_w),
    .w_idx_i       (write_idx_w_q),
    .w_data_i      (operand_w_q),
    .bypass_data_o (bypass_data_1_d)
  );

endmodule

// File: tb/tb_lm32_x_result_stage.sv
// tb_lm32_x_result_stage
//   Directed bench for lm32_x_result_stage: reset, result select and
//   latency, M stall/kill, X bubbles, and the D-stage bypass network.
module tb_lm32_x_result_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] logic_result_x, adder_result_x, shifter_result_x, csr_read_data_x;
  logic [1:0]  result_sel_x;
  logic [4:0]  write_idx_x;
  logic        write_enable_x, valid_x, stall_x, kill_x, stall_m, kill_m;
  logic [4:0]  read_idx_0_d, read_idx_1_d;
  logic [31:0] reg_data_0_d, reg_data_1_d;
  logic [31:0] x_result, operand_m, operand_w, bypass_data_0_d, bypass_data_1_d;
  logic [4:0]  write_idx_m, write_idx_w;
  logic        write_enable_m, valid_m, write_enable_w;

  int errors = 0;
  int checks = 0;

  lm32_x_result_stage dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .logic_result_x   (logic_result_x),
    .adder_result_x   (adder_result_x),
    .shifter_result_x (shifter_result_x),
    .csr_read_data_x  (csr_read_data_x),
    .result_sel_x     (result_sel_x),
    .write_idx_x      (write_idx_x),
    .write_enable_x   (write_enable_x),
    .valid_x          (valid_x),
    .stall_x          (stall_x),
    .kill_x           (kill_x),
    .stall_m          (stall_m),
    .kill_m           (kill_m),
    .read_idx_0_d     (read_idx_0_d),
    .read_idx_1_d     (read_idx_1_d),
    .reg_data_0_d     (reg_data_0_d),
    .reg_data_1_d     (reg_data_1_d),
    .x_result         (x_result),
    .operand_m        (operand_m),
    .write_idx_m      (write_idx_m),
    .write_enable_m   (write_enable_m),
    .valid_m          (valid_m),
    .operand_w        (operand_w),
    .write_idx_w      (write_idx_w),
    .write_enable_w   (write_enable_w),
    .bypass_data_0_d  (bypass_data_0_d),
    .bypass_data_1_d  (bypass_data_1_d)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Put a valid writing instruction in X using the logic-unit result.
  task automatic drive_x(input logic [4:0] idx, input logic [31:0] val);
    valid_x        = 1'b1;
    write_enable_x = 1'b1;
    write_idx_x    = idx;
    result_sel_x   = 2'd0;
    logic_result_x = val;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    tick();
    tick();
    checks++;
    if (valid_m !== 1'b0 || write_enable_m !== 1'b0 || write_enable_w !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: valid_m=%b we_m=%b we_w=%b, required 0 0 0", valid_m, write_enable_m, write_enable_w);
    end
    checks++;
    if (operand_m !== 32'h0 || operand_w !== 32'h0) begin
      errors++;
      $display("FAIL reset_init_data: operand_m=%h operand_w=%h, required 0 0", operand_m, operand_w);
    end
    // Load real data into M, then reset while M is stalled.
    rst_i          = 1'b1;
    valid_x        = 1'b1;
    write_enable_x = 1'b1;
    write_idx_x    = 5'd7;
    result_sel_x   = 2'd1;
    adder_result_x = 32'h0000_1234;
    tick();
    checks++;
    if (valid_m !== 1'b1 || operand_m !== 32'h0000_1234) begin
      errors++;
      $display("FAIL reset_preload: valid_m=%b operand_m=%h, required 1 00001234", valid_m, operand_m);
    end
    stall_m = 1'b1;
    rst_i   = 1'b0;
    tick();
    checks++;
    if (valid_m !== 1'b0 || write_enable_w !== 1'b0 || operand_m !== 32'h0 || write_idx_m !== 5'd0) begin
      errors++;
      $display("FAIL reset_over_stall: valid_m=%b we_w=%b operand_m=%h idx_m=%0d, required 0 0 0 0",
               valid_m, write_enable_w, operand_m, write_idx_m);
    end
    $display("reset: checked init and reset-over-stall");
    rst_i   = 1'b1;
    stall_m = 1'b0;
    valid_x = 1'b0;
    tick();
  endtask

  task automatic test_result_select();
    logic [31:0] exp_val [4];
    exp_val[0] = 32'h1111_1111;
    exp_val[1] = 32'h2222_2222;
    exp_val[2] = 32'h3333_3333;
    exp_val[3] = 32'h4444_4444;
    logic_result_x   = exp_val[0];
    adder_result_x   = exp_val[1];
    shifter_result_x = exp_val[2];
    csr_read_data_x  = exp_val[3];
    for (int s = 0; s < 4; s++) begin
      result_sel_x   = 2'(s);
      valid_x        = 1'b1;
      write_enable_x = 1'b1;
      write_idx_x    = 5'd3;
      #1;
      checks++;
      if (x_result !== exp_val[s]) begin
        errors++;
        $display("FAIL sel%0d_x_result: got %h, required %h", s, x_result, exp_val[s]);
      end
      tick();
      checks++;
      if (operand_m !== exp_val[s] || write_enable_m !== 1'b1 || write_idx_m !== 5'd3) begin
        errors++;
        $display("FAIL sel%0d_m: operand_m=%h we_m=%b idx_m=%0d, required %h 1 3",
                 s, operand_m, write_enable_m, write_idx_m, exp_val[s]);
      end
      valid_x = 1'b0;
      tick();
      checks++;
      if (operand_w !== exp_val[s] || write_enable_w !== 1'b1 || write_idx_w !== 5'd3) begin
        errors++;
        $display("FAIL sel%0d_w: operand_w=%h we_w=%b idx_w=%0d, required %h 1 3",
                 s, operand_w, write_enable_w, write_idx_w, exp_val[s]);
      end
      tick();
      checks++;
      if (write_enable_w !== 1'b0) begin
        errors++;
        $display("FAIL sel%0d_w_pulse: we_w=%b, required 0", s, write_enable_w);
      end
      $display("select %0d: value %h through M and W", s, exp_val[s]);
    end
  endtask

  task automatic test_stall_kill_m();
    drive_x(5'd9, 32'hDEAD_BEEF);
    tick();
    valid_x        = 1'b0;
    logic_result_x = 32'h0;
    stall_m        = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      kill_m = (c == 2);
      tick();
      checks++;
      if (operand_m !== 32'hDEAD_BEEF || write_idx_m !== 5'd9) begin
        errors++;
        $display("FAIL stall_hold_c%0d: operand_m=%h idx_m=%0d, required deadbeef 9", c, operand_m, write_idx_m);
      end
      checks++;
      if (valid_m !== (c == 1) || write_enable_w !== 1'b0) begin
        errors++;
        $display("FAIL stall_valid_c%0d: valid_m=%b we_w=%b, required %b 0", c, valid_m, write_enable_w, (c == 1));
      end
    end
    kill_m  = 1'b0;
    stall_m = 1'b0;
    tick();
    checks++;
    if (write_enable_w !== 1'b0) begin
      errors++;
      $display("FAIL stall_killed_no_write: we_w=%b, required 0", write_enable_w);
    end
    $display("stall_m 3 cycles with kill_m in cycle 2: hold and no writeback");
  endtask

  task automatic test_bubble();
    drive_x(5'd4, 32'h0000_0044);
    stall_x = 1'b1;
    tick();
    checks++;
    if (valid_m !== 1'b0 || write_enable_m !== 1'b0) begin
      errors++;
      $display("FAIL bubble_stall_x: valid_m=%b we_m=%b, required 0 0", valid_m, write_enable_m);
    end
    stall_x = 1'b0;
    kill_x  = 1'b1;
    tick();
    checks++;
    if (valid_m !== 1'b0) begin
      errors++;
      $display("FAIL bubble_kill_x: valid_m=%b, required 0", valid_m);
    end
    stall_x = 1'b1;
    tick();
    checks++;
    if (valid_m !== 1'b0) begin
      errors++;
      $display("FAIL bubble_kill_and_stall: valid_m=%b, required 0", valid_m);
    end
    stall_x = 1'b0;
    kill_x  = 1'b0;
    tick();
    checks++;
    if (valid_m !== 1'b1 || write_enable_m !== 1'b1 || operand_m !== 32'h0000_0044) begin
      errors++;
      $display("FAIL bubble_recover: valid_m=%b we_m=%b operand_m=%h, required 1 1 00000044",
               valid_m, write_enable_m, operand_m);
    end
    valid_x = 1'b0;
    tick();
    tick();
    $display("bubbles: stall_x, kill_x, both, then recovery");
  endtask

  task automatic test_bypass();
    reg_data_0_d = 32'h0000_0099;
    reg_data_1_d = 32'h0000_0077;
    read_idx_0_d = 5'd5;
    read_idx_1_d = 5'd6;
    // W <- 0xC, M <- 0xB, X = 0xA, all to r5.
    drive_x(5'd5, 32'h0000_000C);
    tick();
    drive_x(5'd5, 32'h0000_000B);
    tick();
    drive_x(5'd5, 32'h0000_000A);
    #1;
    checks++;
    if (bypass_data_0_d !== 32'h0000_000A) begin
      errors++;
      $display("FAIL bypass_x: got %h, required 0000000a", bypass_data_0_d);
    end
    checks++;
    if (bypass_data_1_d !== 32'h0000_0077) begin
      errors++;
      $display("FAIL bypass_no_hit: got %h, required 00000077", bypass_data_1_d);
    end
    valid_x = 1'b0;
    #1;
    checks++;
    if (bypass_data_0_d !== 32'h0000_000B) begin
      errors++;
      $display("FAIL bypass_m: got %h, required 0000000b", bypass_data_0_d);
    end
    // Rebuild with M empty and W holding 0xC.
    drive_x(5'd5, 32'h0000_000C);
    tick();
    valid_x = 1'b0;
    tick();
    #1;
    checks++;
    if (bypass_data_0_d !== 32'h0000_000C) begin
      errors++;
      $display("FAIL bypass_w: got %h, required 0000000c", bypass_data_0_d);
    end
    // A killed X must not forward; W still supplies 0xC.
    drive_x(5'd5, 32'h0000_000A);
    kill_x = 1'b1;
    #1;
    checks++;
    if (bypass_data_0_d !== 32'h0000_000C) begin
      errors++;
      $display("FAIL bypass_killed_x: got %h, required 0000000c", bypass_data_0_d);
    end
    kill_x  = 1'b0;
    valid_x = 1'b0;
    tick();
    #1;
    checks++;
    if (bypass_data_0_d !== 32'h0000_0099) begin
      errors++;
      $display("FAIL bypass_regfile: got %h, required 00000099", bypass_data_0_d);
    end
    // r0 is never forwarded, even with X and M both writing r0.
    reg_data_1_d = 32'h0;
    read_idx_1_d = 5'd0;
    drive_x(5'd0, 32'h0000_0055);
    tick();
    #1;
    checks++;
    if (bypass_data_1_d !== 32'h0 || write_enable_m !== 1'b1) begin
      errors++;
      $display("FAIL bypass_r0: got %h we_m=%b, required 00000000 1", bypass_data_1_d, write_enable_m);
    end
    valid_x = 1'b0;
    $display("bypass: X > M > W > regfile, killed X and r0 rules");
  endtask

  initial begin
    rst_i            = 1'b0;
    logic_result_x   = '0;
    adder_result_x   = '0;
    shifter_result_x = '0;
    csr_read_data_x  = '0;
    result_sel_x     = 2'd0;
    write_idx_x      = '0;
    write_enable_x   = 1'b0;
    valid_x          = 1'b0;
    stall_x          = 1'b0;
    kill_x           = 1'b0;
    stall_m          = 1'b0;
    kill_m           = 1'b0;
    read_idx_0_d     = '0;
    read_idx_1_d     = '0;
    reg_data_0_d     = '0;
    reg_data_1_d     = '0;
    #2;
    test_reset();
    test_result_select();
    test_stall_kill_m();
    test_bubble();
    test_bypass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
